mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 103 ++++++++++
 tb/tb_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering CPU read/write requests after a fixed latency.
// Includes a backdoor preload port and sticky error flags.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_read,
  input  logic                           mem_write,
  input  logic [3:0]                     mem_byte_enable,
  input  logic [31:0]                    mem_address,
  input  logic [31:0]                    mem_wdata,
  output logic                           mem_resp,
  output logic [31:0]                    mem_rdata,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  output logic                           err_rw,
  output logic                           err_addr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        oor_q, oor_d;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_rw_q, err_rw_d;
  logic        err_addr_q, err_addr_d;
  logic        accept, addr_oor, commit;

  // The _d view of the latched fields is used at the commit edge so LATENCY=1 sees the live request.
  always_comb begin
    addr_oor   = {1'b0, mem_address} >= LIMIT;
    accept     = state_q == IDLE && (mem_read ^ mem_write);
    state_d    = state_q == IDLE ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
               : state_q == WAIT ? (!(mem_read || mem_write) ? IDLE : cnt_q == '0 ? RESP : WAIT)
               : IDLE;
    cnt_d      = accept ? CNT_INIT : (state_q == WAIT && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    we_d       = accept ? mem_write : we_q;
    idx_d      = accept ? mem_address[AW+1:2] : idx_q;
    be_d       = accept ? mem_byte_enable : be_q;
    wdata_d    = accept ? mem_wdata : wdata_q;
    oor_d      = accept ? addr_oor : oor_q;
    commit     = state_d == RESP;
    resp_d     = commit;
    rdata_d    = (commit && !we_d) ? (oor_d ? '0 : mem[idx_d]) : rdata_q;
    err_rw_d   = err_rw_q | (state_q == IDLE && mem_read && mem_write);
    err_addr_d = err_addr_q | (accept && addr_oor);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      err_rw_q   <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      err_rw_q   <= err_rw_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Backdoor assignment comes last so it overrides a CPU write to the same word.
  always_ff @(posedge clk) begin
    if (rst && commit && we_d && !oor_d)
      for (int i = 0; i < 4; i++)
        if (be_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign err_rw    = err_rw_q;
  assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus hand sequences for mem_responder (LATENCY 3 and 1).
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, ld_en = 1'b0;
  logic [3:0] be = '0;
  logic [31:0] addr = '0, wdata = '0, ld_data = '0, rdata;
  logic [7:0] ld_addr = '0;
  logic resp, err_rw, err_addr;
  logic r1_read = 1'b0, r1_write = 1'b0, ld1_en = 1'b0;
  logic [3:0] be1 = '0;
  logic [31:0] addr1 = '0, wdata1 = '0, ld1_data = '0, rdata1;
  logic [7:0] ld1_addr = '0;
  logic resp1, err_rw1, err_addr1;
  int nvec = 0, nfail = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u0 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
    .mem_resp(resp), .mem_rdata(rdata), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .err_rw(err_rw), .err_addr(err_addr));

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_read(r1_read), .mem_write(r1_write),
    .mem_byte_enable(be1), .mem_address(addr1), .mem_wdata(wdata1),
    .mem_resp(resp1), .mem_rdata(rdata1), .ld_en(ld1_en), .ld_addr(ld1_addr),
    .ld_data(ld1_data), .err_rw(err_rw1), .err_addr(err_addr1));

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic        ld;
    logic [7:0]  la;
    logic [31:0] ldd;
    logic [31:0] exp;
    logic        ea;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Holds the request until mem_resp; scrambles address/data after acceptance to prove latching.
  task automatic run(input string nm, input vec_t v);
    int n;
    @(negedge clk);
    mem_read = !v.wr; mem_write = v.wr; addr = v.a; be = v.b; wdata = v.d;
    n = -1;
    for (int k = 0; k < 20 && n < 0; k++) begin
      @(negedge clk);
      if (resp) n = k;
      if (k == 0) begin addr = 32'hFFFF_FFF0; be = ~v.b; wdata = ~v.d; end
      if (k == 1 && v.ld) begin ld_en = 1'b1; ld_addr = v.la; ld_data = v.ldd; end
      if (k == 2) ld_en = 1'b0;
    end
    ld_en = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'd2);
    if (!v.wr) chk({nm, " rdata"}, rdata, v.exp);
    chk({nm, " err_addr"}, {31'd0, err_addr}, {31'd0, v.ea});
    @(negedge clk);
    chk({nm, " resp_1cyc"}, {31'd0, resp}, 32'd0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic seen;
    tv[0]  = '{1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'hDEADBEEF, 1'b0};
    tv[1]  = '{1'b1, 32'h10,  4'h5, 32'h11223344, 1'b0, 8'd0, 32'h0,        32'h0,        1'b0};
    tv[2]  = '{1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'hDE22BE44, 1'b0};
    tv[3]  = '{1'b1, 32'h14,  4'hF, 32'hCAFEF00D, 1'b0, 8'd0, 32'h0,        32'h0,        1'b0};
    tv[4]  = '{1'b0, 32'h14,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'hCAFEF00D, 1'b0};
    tv[5]  = '{1'b1, 32'h14,  4'h0, 32'hFFFFFFFF, 1'b0, 8'd0, 32'h0,        32'h0,        1'b0};
    tv[6]  = '{1'b0, 32'h14,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'hCAFEF00D, 1'b0};
    tv[7]  = '{1'b0, 32'h13,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'hDE22BE44, 1'b0};
    tv[8]  = '{1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 8'd0, 32'h0,        32'hDE22BE44, 1'b0};
    tv[9]  = '{1'b1, 32'h18,  4'hF, 32'h11111111, 1'b1, 8'd6, 32'h22222222, 32'h0,        1'b0};
    tv[10] = '{1'b0, 32'h18,  4'hF, 32'h0,        1'b1, 8'd6, 32'h33333333, 32'h22222222, 1'b0};
    tv[11] = '{1'b0, 32'h18,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'h33333333, 1'b0};
    tv[12] = '{1'b0, 32'h400, 4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'h0,        1'b1};
    tv[13] = '{1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b0, 8'd0, 32'h0,        32'h0,        1'b1};
    tv[14] = '{1'b0, 32'h0,   4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'h12345678, 1'b1};
    tv[15] = '{1'b0, 32'h3FC, 4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'hA5A5A5A5, 1'b1};
    tv[16] = '{1'b0, 32'h1C,  4'hF, 32'h0,        1'b0, 8'd0, 32'h0,        32'h77777777, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst resp",  {31'd0, resp}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst errs",  {30'd0, err_rw, err_addr}, 32'd0);
    chk("rst u1",    {rdata1[29:0], resp1, err_rw1 | err_addr1}, 32'd0);
    rst = 1'b1;

    preload(8'd4, 32'hDEADBEEF);
    preload(8'd0, 32'h12345678);
    preload(8'd255, 32'hA5A5A5A5);
    preload(8'd7, 32'h77777777);

    for (int i = 0; i < 17; i++) run($sformatf("v%0d", i), tv[i]);

    // Both request lines high in IDLE: never accepted, flags err_rw.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h10; wdata = 32'h0; be = 4'hF;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= resp; end
    mem_read = 1'b0; mem_write = 1'b0;
    chk("rw noresp", {31'd0, seen}, 32'd0);
    chk("rw err", {31'd0, err_rw}, 32'd1);
    v = tv[2]; v.ea = 1'b1;
    run("rw unchanged", v);

    // Dropping both lines while in WAIT aborts the write.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h14; wdata = 32'h0; be = 4'hF;
    @(negedge clk);
    mem_write = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= resp; end
    chk("abort noresp", {31'd0, seen}, 32'd0);
    v = tv[4]; v.ea = 1'b1;
    run("abort unchanged", v);

    // Back-to-back reads on the LATENCY=1 instance.
    @(negedge clk);
    ld1_en = 1'b1; ld1_addr = 8'd1; ld1_data = 32'h1;
    @(negedge clk);
    ld1_addr = 8'd2; ld1_data = 32'h2;
    @(negedge clk);
    ld1_en = 1'b0; r1_read = 1'b1; addr1 = 32'h4;
    @(negedge clk);
    chk("l1 resp0", {31'd0, resp1}, 32'd1);
    chk("l1 rdata0", rdata1, 32'h1);
    addr1 = 32'h8;
    @(negedge clk);
    chk("l1 gap", {31'd0, resp1}, 32'd0);
    @(negedge clk);
    chk("l1 resp1", {31'd0, resp1}, 32'd1);
    chk("l1 rdata1", rdata1, 32'h2);
    r1_read = 1'b0;
    @(negedge clk);
    chk("l1 end", {31'd0, resp1}, 32'd0);

    // Reset during WAIT abandons the write.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h1C; wdata = 32'h0; be = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid rst outs", {rdata[28:0], resp, err_rw, err_addr}, 32'd0);
    @(negedge clk);
    mem_write = 1'b0; rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= resp; end
    chk("mid rst noresp", {31'd0, seen}, 32'd0);
    chk("mid rst errs", {30'd0, err_rw, err_addr}, 32'd0);
    v = tv[16]; v.ea = 1'b0;
    run("mid rst unchanged", v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
